call_stack: RTL

// - Parametrised hardware call/return-address stack for the core datapath; replaces the fixed single-purpose stack in stage one.
// - Push saves the return address (pc+1) on a call; pop supplies the return target to next-PC selection in the same cycle.
// - Adds configurable depth/width, replace-top on simultaneous push/pop, flush, occupancy count and sticky overflow/underflow flags.
// - Full-stack policy is selectable: saturate or wrap.

---
 rtl/core_pkg.sv | 13 +
 rtl/stack_ram.sv | 23 ++
 rtl/call_stack.sv | 135 +++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: address width and the stack-op encoding used by the control stage.
package core_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_REPL = 2'd3
  } stack_op_e;

endpackage

// File: rtl/stack_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Call/return-address stack: pointer, occupancy and sticky flag control around stack_ram.
module call_stack
  import core_pkg::*;
#(
  parameter  int unsigned WIDTH        = ADDR_W,
  parameter  int unsigned DEPTH        = 8,
  parameter  int unsigned WRAP_ON_FULL = 0,
  localparam int unsigned CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] stack_out,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;

  logic [PW-1:0]    sp_inc, top;
  logic             we;
  logic [PW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;
  stack_op_e        op;

  // Explicit modulo-DEPTH pointer arithmetic; DEPTH need not be a power of two.
  assign sp_inc = (sp_q == PW'(DEPTH - 1)) ? '0 : sp_q + PW'(1);
  assign top    = (sp_q == '0) ? PW'(DEPTH - 1) : sp_q - PW'(1);

  always_comb begin
    op = OP_NONE;
    if (push && pop && !empty_q) op = OP_REPL;
    else if (push)               op = OP_PUSH;
    else if (pop)                op = OP_POP;
  end

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
    waddr   = sp_q;
    if (flush) begin
      sp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          if (!full_q) begin
            we      = 1'b1;
            sp_d    = sp_inc;
            count_d = count_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
            // Circular mode overwrites the oldest entry, which sits at sp when full.
            if (WRAP_ON_FULL != 0) begin
              we   = 1'b1;
              sp_d = sp_inc;
            end
          end
        end
        OP_POP: begin
          if (!empty_q) begin
            sp_d    = top;
            count_d = count_q - CW'(1);
          end else begin
            unf_d = 1'b1;
          end
        end
        OP_REPL: begin
          we    = 1'b1;
          waddr = top;
        end
        default: ;
      endcase
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we && rst),
    .waddr_i (waddr),
    .wdata_i (push_data),
    .raddr_i (top),
    .rdata_o (rdata)
  );

  assign stack_out = empty_q ? '0 : rdata;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
